epu_request_driver: RTL
=======================

Name: epu_request_driver

Overview:
Initiator side of the EPU verify interface. Assembles a 32-word stream (signature, key, message) from a 32-bit valid/ready input and issues one job to the EPU over its valid/ready port. It then waits for completion and returns a single pass/fail response word on a valid/ready output. It sits between the host-facing word bus and the EPU, and owns framing checks and the completion timeout.

Parameters:
TIMEOUT_CYCLES, 2^20, max cycles from EPU accept to completion before the job is aborted as timed out
CNT_W, 21, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
s_data  in  32  input stream word
s_valid  in  1  input word valid
s_ready  out  1  driver accepts input word
s_last  in  1  marks final word of a request frame
epu_signature  out  512  signature to EPU
epu_key  out  256  public key to EPU
epu_message  out  256  message to EPU
epu_valid  out  1  job request to EPU
epu_ready  in  1  EPU idle / accepting; also completion indicator
epu_result  in  1  EPU verify result, sampled at completion
r_valid  out  1  response valid
r_ready  in  1  response consumer ready
r_result  out  1  1 = signature verified
r_error  out  2  0 ok, 1 framing error, 2 timeout

Behaviour:
- Reset (resetn low, async): state LOAD, word index 0, s_ready=0 on the reset cycle and 1 on the first cycle after release, epu_valid=0, r_valid=0, r_result=0, r_error=0, operand registers all zero, timeout counter 0. Reset mid-job drops the job silently; no response is produced.
- Word map: a word is accepted when s_valid&&s_ready. Index i 0..15 -> epu_signature[32i+31:32i]; 16..23 -> epu_key[32(i-16)+31:...]; 24..31 -> epu_message[32(i-24)+31:...]. Words are little-endian within each field.
- States:
  LOAD: s_ready=1. Each accepted word is stored and the index increments. If s_last is accepted at index 31, go to ISSUE. If s_last is accepted at index <31, go to RESP with r_error=1. If index 31 is accepted without s_last, enter DRAIN.
  DRAIN: s_ready=1. Discard words until s_last is accepted, then go to RESP with r_error=1.
  ISSUE: s_ready=0, epu_valid=1. Operands are held stable. On epu_valid&&epu_ready, go to BUSY next cycle with epu_valid=0. epu_valid must not drop before this handshake.
  BUSY: wait for epu_ready=0 (EPU has started), then go to WAIT. The timeout counter runs here.
  WAIT: on epu_ready=1, capture epu_result into r_result with r_error=0 and go to RESP. The timeout counter runs here.
  Timeout: the counter resets to 0 on the handshake and increments each cycle in BUSY/WAIT. When it reaches TIMEOUT_CYCLES, go to RESP with r_result=0 and r_error=2.
  RESP: r_valid=1, with r_result/r_error held. On r_valid&&r_ready, go to LOAD next cycle, clear the index, and set s_ready=1. s_ready stays 0 throughout RESP; there is no prefetch of the next frame.
- EPU contract: epu_ready falls no later than 1 cycle after accept. If epu_ready is still 1 in the cycle after accept, BUSY treats that as immediate completion: result is captured and the state goes to RESP (zero-latency EPU supported).
- Latency: the last input word reaches epu_valid high 1 cycle later. EPU completion (epu_ready rising) reaches r_valid high 1 cycle later.
- On any error, r_result is forced to 0.
- Operand registers are not cleared between jobs; they are overwritten by the next frame.

Test Plan:
- Good frame: 32 words, s_last on word 31, with signature words 0x0000_0000..0x0000_000F, key words 0xA0..0xA7, message words 0xB0..0xB7 → epu_signature[31:0]=0, epu_key[31:0]=0xA0, epu_message[255:224]=0xB7; epu_valid asserts 1 cycle after the last word.
- EPU model drops epu_ready for 100 cycles then raises it with epu_result=1 → r_valid is asserted 1 cycle after the rise, r_result=1, r_error=0. With r_ready held low 5 cycles, the outputs stay stable; after the handshake s_ready=1.
- s_last on word 9 → no epu_valid; r_valid with r_error=1, r_result=0.
- 40-word frame with s_last on word 39 → 8 words drained, r_error=1, EPU never requested.
- TIMEOUT_CYCLES=50 and the EPU never re-raises ready → r_error=2 exactly 50 cycles after the accept handshake, r_result=0.
- resetn pulsed low during WAIT → all outputs at reset values immediately; a subsequent good frame completes normally.

Source files
------------

// File: rtl/epu_request_driver.sv
// Host-side initiator for the EPU verify port: collects a 32-word operand frame, issues one job,
// waits for completion (with timeout) and returns a single pass/fail response word.
module epu_request_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1048576,
    parameter int unsigned CNT_W          = 21
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    output logic [511:0] epu_signature,
    output logic [255:0] epu_key,
    output logic [255:0] epu_message,
    output logic         epu_valid,
    input  logic         epu_ready,
    input  logic         epu_result,
    output logic         r_valid,
    input  logic         r_ready,
    output logic         r_result,
    output logic [1:0]   r_error
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrFraming = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    typedef enum logic [2:0] {
        StLoad,
        StDrain,
        StIssue,
        StBusy,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              armed_q;
    logic [4:0]        idx_q, idx_d;
    logic [1023:0]     op_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              res_q, res_d;
    logic [1:0]        err_q, err_d;
    logic              word_acc;
    logic              last_idx;
    logic              timed_out;

    assign word_acc  = s_valid && s_ready;
    assign last_idx  = (idx_q == 5'd31);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timed_out = (cnt_inc == TimeoutVal);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and response capture
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            StLoad: begin
                if (word_acc) begin
                    if (s_last) begin
                        if (last_idx) begin
                            state_d = StIssue;
                        end else begin
                            state_d = StResp;
                            res_d   = 1'b0;
                            err_d   = ErrFraming;
                        end
                    end else if (last_idx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (word_acc && s_last) begin
                    state_d = StResp;
                    res_d   = 1'b0;
                    err_d   = ErrFraming;
                end
            end
            StIssue: begin
                if (epu_ready) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Ready still high one cycle after accept means a zero-latency EPU finished.
                if (epu_ready) begin
                    state_d = StResp;
                    res_d   = epu_result;
                    err_d   = ErrOk;
                end else if (timed_out) begin
                    state_d = StResp;
                    res_d   = 1'b0;
                    err_d   = ErrTimeout;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (epu_ready) begin
                    state_d = StResp;
                    res_d   = epu_result;
                    err_d   = ErrOk;
                end else if (timed_out) begin
                    state_d = StResp;
                    res_d   = 1'b0;
                    err_d   = ErrTimeout;
                end
            end
            StResp: begin
                if (r_ready) begin
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        s_ready   = armed_q && ((state_q == StLoad) || (state_q == StDrain));
        epu_valid = (state_q == StIssue);
        r_valid   = (state_q == StResp);
    end

    // Datapath next-state: word index and timeout counter
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if ((state_q == StLoad) && word_acc) begin
            idx_d = idx_q + 5'd1;
        end
        if ((state_q == StResp) && r_ready) begin
            idx_d = 5'd0;
        end
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if ((state_q == StBusy) || (state_q == StWait)) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed_q <= 1'b0;
            idx_q   <= 5'd0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= 1'b0;
            err_q   <= ErrOk;
        end else begin
            armed_q <= 1'b1;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            // Operands live as one flat array: signature words 0-15, key 16-23, message 24-31.
            if ((state_q == StLoad) && word_acc) begin
                op_q[{idx_q, 5'd0} +: 32] <= s_data;
            end
        end
    end

    assign epu_signature = op_q[511:0];
    assign epu_key       = op_q[767:512];
    assign epu_message   = op_q[1023:768];
    assign r_result      = res_q;
    assign r_error       = err_q;

endmodule
